// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes, FSM states and index decode for the round-robin arbiter
package rr_arbiter8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_arbiter8_enc.sv
// rr_prio_encoder8: rotating-priority search, first set bit from ptr upward with one index maskable
module rr_prio_encoder8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mask_en,
  input  logic [IDX_W-1:0] mask_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             found
);
  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  always_comb begin
    masked = req & ~(mask_en ? idx2oh(mask_idx) : '0);
    dbl = {masked, masked} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
    found = |rot;
    win_idx = off + ptr;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot/encoded grant and hold timeout
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  state_e           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, enc_ptr, win_idx, idx_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             found, busy, rel, tmo, valid_nxt, preempt_nxt;
  assign busy    = state == ST_BUSY;
  assign rel     = busy && !req[grant_idx];
  assign tmo     = busy && (MAX_HOLD > 0) && req[grant_idx] && hold_cnt == HOLD_LAST;
  assign enc_ptr = busy ? grant_idx + 1'b1 : ptr;
  rr_prio_encoder8 u_enc (
    .req      (req),
    .ptr      (enc_ptr),
    .mask_en  (busy),
    .mask_idx (grant_idx),
    .win_idx  (win_idx),
    .found    (found)
  );
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = hold_cnt + 1'b1;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    preempt_nxt = 1'b0;
    if (!busy || rel || tmo) begin
      ptr_nxt     = enc_ptr;
      preempt_nxt = tmo;
      cnt_nxt     = '0;
      state_nxt   = found ? ST_BUSY : ST_IDLE;
      grant_nxt   = found ? idx2oh(win_idx) : '0;
      idx_nxt     = found ? win_idx : grant_idx;
      valid_nxt   = found;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= cnt_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      preempt     <= preempt_nxt;
    end
  end
endmodule
